// File: rtl/dsp_bus_ctl_bank.sv
// DSP external-bus strobe decoder driving a bank of latch/pulse control outputs.
// Optional watchdog returns all outputs to RESET_VAL when DSP_BUS_CTL_WDOG_EN is defined.
module dsp_bus_ctl_bank #(
  parameter int unsigned         NUM_CH      = 8,
  parameter int unsigned         AB_W        = 11,
  parameter logic [AB_W-1:0]     BASE_ADDR   = 11'h400,
  parameter logic [NUM_CH-1:0]   MODE_MASK   = 8'hF0,
  parameter logic [NUM_CH-1:0]   RESET_VAL   = 8'h00,
  parameter int unsigned         PULSE_W     = 8,
  parameter logic [PULSE_W-1:0]  PULSE_LEN   = 8'd5,
  parameter logic [15:0]         WDOG_CYCLES = 16'd50000
) (
  input  logic              clkDspIn,
  input  logic              dsp_reset,
  input  logic              we,
  input  logic              re,
  input  logic [AB_W-1:0]   ab,
  output logic [NUM_CH-1:0] ctl_out,
  output logic              evt_hit,
  output logic              wdog_trip
);

  logic            we_buf_q, we_buf2_q, re_buf_q, re_buf2_q;
  logic            we_deb_q, re_deb_q;
  logic            smp_q, we_arm_q, re_arm_q;
  logic [AB_W-1:0] ab_buf_q;
  logic            we_deb, re_deb, wr_evt, rd_evt, hit;
  logic [AB_W-1:0] off, off_q;
  logic            op_wr_q, op_rd_q;

  logic [NUM_CH-1:0]  ctl_q, ctl_d;
  logic               evt_hit_q, evt_hit_d;
  logic [PULSE_W-1:0] cnt_q [NUM_CH];
  logic [PULSE_W-1:0] cnt_d [NUM_CH];
  logic               wd_fire;

  assign we_deb = we_buf_q | we_buf2_q;
  assign re_deb = re_buf_q | re_buf2_q;

  // A strobe held low across reset release must not fire: edges count only
  // once a genuine high sample has been seen after reset.
  assign wr_evt = ~we_deb & we_deb_q & we_arm_q;
  assign rd_evt = ~re_deb & re_deb_q & re_arm_q;

  assign off = ab_buf_q - BASE_ADDR;
  assign hit = (ab_buf_q >= BASE_ADDR) && (off < AB_W'(NUM_CH));

  always_ff @(posedge clkDspIn or negedge dsp_reset) begin
    if (!dsp_reset) begin
      we_buf_q  <= 1'b1;
      we_buf2_q <= 1'b1;
      re_buf_q  <= 1'b1;
      re_buf2_q <= 1'b1;
      we_deb_q  <= 1'b1;
      re_deb_q  <= 1'b1;
      smp_q     <= 1'b0;
      we_arm_q  <= 1'b0;
      re_arm_q  <= 1'b0;
      ab_buf_q  <= '0;
      op_wr_q   <= 1'b0;
      op_rd_q   <= 1'b0;
      off_q     <= '0;
    end else begin
      we_buf_q  <= we;
      we_buf2_q <= we_buf_q;
      re_buf_q  <= re;
      re_buf2_q <= re_buf_q;
      we_deb_q  <= we_deb;
      re_deb_q  <= re_deb;
      smp_q     <= 1'b1;
      we_arm_q  <= we_arm_q | (smp_q & we_buf_q);
      re_arm_q  <= re_arm_q | (smp_q & re_buf_q);
      ab_buf_q  <= ab;
      op_wr_q   <= wr_evt & ~rd_evt & hit;
      op_rd_q   <= rd_evt & ~wr_evt & hit;
      off_q     <= off;
    end
  end

  assign evt_hit_d = op_wr_q | op_rd_q;

  always_comb begin
    ctl_d = ctl_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (MODE_MASK[i]) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - PULSE_W'(1);
        if (op_wr_q && off_q == AB_W'(i))      cnt_d[i] = PULSE_LEN;
        else if (op_rd_q && off_q == AB_W'(i)) cnt_d[i] = '0;
        ctl_d[i] = (cnt_d[i] != '0);
      end else if (op_wr_q && off_q == AB_W'(i)) begin
        ctl_d[i] = 1'b1;
      end else if (op_rd_q && off_q == AB_W'(i)) begin
        ctl_d[i] = 1'b0;
      end
      if (wd_fire) begin
        cnt_d[i] = '0;
        ctl_d[i] = RESET_VAL[i];
      end
    end
  end

  always_ff @(posedge clkDspIn or negedge dsp_reset) begin
    if (!dsp_reset) begin
      ctl_q     <= RESET_VAL;
      evt_hit_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      ctl_q     <= ctl_d;
      evt_hit_q <= evt_hit_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign ctl_out = ctl_q;
  assign evt_hit = evt_hit_q;

`ifdef DSP_BUS_CTL_WDOG_EN
  logic [15:0] wd_q, wd_d;
  logic        wdog_trip_q;

  // A hit landing on the terminal count wins and restarts the count.
  assign wd_fire = (wd_q == WDOG_CYCLES - 16'd1) && !evt_hit_d;
  assign wd_d    = (evt_hit_d || wd_fire) ? 16'd0 : wd_q + 16'd1;

  always_ff @(posedge clkDspIn or negedge dsp_reset) begin
    if (!dsp_reset) begin
      wd_q        <= 16'd0;
      wdog_trip_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      wdog_trip_q <= wd_fire;
    end
  end

  assign wdog_trip = wdog_trip_q;
`else
  assign wd_fire   = 1'b0;
  assign wdog_trip = 1'b0 & (|WDOG_CYCLES);
`endif

endmodule

// File: tb/tb_dsp_bus_ctl_bank.sv
// Scoreboard bench for dsp_bus_ctl_bank: every change of {wdog_trip, evt_hit, ctl_out}
// is matched against a cycle-stamped expectation queued by the stimulus.
module tb_dsp_bus_ctl_bank;
  logic        clkDspIn  = 1'b0;
  logic        dsp_reset = 1'b0;
  logic        we = 1'b1;
  logic        re = 1'b1;
  logic [10:0] ab = '0;
  logic [7:0]  ctl_out;
  logic        evt_hit, wdog_trip;

  typedef struct {
    int         cyc;
    logic [9:0] obs;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [9:0] last_obs = '0;
  logic [9:0] mon_obs;
  exp_t       mon_e;
  int         b;

  dsp_bus_ctl_bank #(.WDOG_CYCLES(16'd100)) dut (
    .clkDspIn (clkDspIn),
    .dsp_reset(dsp_reset),
    .we       (we),
    .re       (re),
    .ab       (ab),
    .ctl_out  (ctl_out),
    .evt_hit  (evt_hit),
    .wdog_trip(wdog_trip)
  );

  always #5 clkDspIn = ~clkDspIn;

  // Insert keeping the queue ordered by cycle.
  task automatic push(input int c, input logic t, input logic h, input logic [7:0] v);
    exp_t e;
    int   k;
    e.cyc = c;
    e.obs = {t, h, v};
    k = sb.size();
    while (k > 0 && sb[k-1].cyc > c) k--;
    sb.insert(k, e);
  endtask

  // Called at a falling edge; leaves the caller at a falling edge.
  task automatic strobe(input logic w, input logic r, input logic [10:0] a,
                        input int low, input int gap);
    ab = a;
    we = ~w;
    re = ~r;
    repeat (low) @(negedge clkDspIn);
    we = 1'b1;
    re = 1'b1;
    repeat (gap) @(negedge clkDspIn);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  always @(posedge clkDspIn) begin
    cyc++;
    #1;
    mon_obs = {wdog_trip, evt_hit, ctl_out};
    if (mon_en && mon_obs !== last_obs) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, mon_obs);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || mon_e.obs !== mon_obs) begin
          errors++;
          $display("FAIL out_event got cyc=%0d val=%h required cyc=%0d val=%h",
                   cyc, mon_obs, mon_e.cyc, mon_e.obs);
        end
      end
    end
    last_obs = mon_obs;
  end

  initial begin
    repeat (3) @(negedge clkDspIn);
    chk("reset_ctl_out", ctl_out, 8'h00);
    chk("reset_evt_hit", {7'd0, evt_hit}, 8'h00);
    chk("reset_wdog_trip", {7'd0, wdog_trip}, 8'h00);
    dsp_reset = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clkDspIn);

    // latch ch2: set, repeat set, clear
    b = cyc; push(b+4, 0, 1, 8'h04); push(b+5, 0, 0, 8'h04);
    strobe(1, 0, 11'h402, 3, 8);
    b = cyc; push(b+4, 0, 1, 8'h04); push(b+5, 0, 0, 8'h04);
    strobe(1, 0, 11'h402, 2, 8);
    b = cyc; push(b+4, 0, 1, 8'h00); push(b+5, 0, 0, 8'h00);
    strobe(0, 1, 11'h402, 3, 8);

    // pulse ch5: 5 cycles
    b = cyc; push(b+4, 0, 1, 8'h20); push(b+5, 0, 0, 8'h20); push(b+9, 0, 0, 8'h00);
    strobe(1, 0, 11'h405, 2, 10);

    // pulse ch5 retriggered 3 cycles in: 8 cycles high
    b = cyc;
    push(b+4, 0, 1, 8'h20); push(b+5, 0, 0, 8'h20);
    push(b+7, 0, 1, 8'h20); push(b+8, 0, 0, 8'h20); push(b+12, 0, 0, 8'h00);
    strobe(1, 0, 11'h405, 2, 1);
    strobe(1, 0, 11'h405, 2, 12);

    // pulse ch6 aborted by read 2 cycles in
    b = cyc;
    push(b+4, 0, 1, 8'h40); push(b+5, 0, 0, 8'h40);
    push(b+6, 0, 1, 8'h00); push(b+7, 0, 0, 8'h00);
    strobe(1, 0, 11'h406, 2, 0);
    strobe(0, 1, 11'h406, 2, 8);

    // miss above range
    strobe(1, 0, 11'h408, 3, 8);
    // read hit on idle pulse channel: strobe only
    b = cyc; push(b+4, 0, 1, 8'h00); push(b+5, 0, 0, 8'h00);
    strobe(0, 1, 11'h404, 2, 8);
    // we and re together, 1-cycle glitch, miss below range
    strobe(1, 1, 11'h401, 3, 8);
    strobe(1, 0, 11'h401, 1, 8);
    strobe(1, 0, 11'h3FF, 2, 8);

    // reset mid-pulse with a fresh strobe held low across release
    b = cyc; push(b+4, 0, 1, 8'h80); push(b+5, 0, 0, 8'h80);
    strobe(1, 0, 11'h407, 2, 3);
    ab = 11'h407;
    we = 1'b0;
    @(negedge clkDspIn);
    push(cyc+1, 0, 0, 8'h00);
    dsp_reset = 1'b0;
    repeat (2) @(negedge clkDspIn);
    dsp_reset = 1'b1;
    repeat (5) @(negedge clkDspIn);
    we = 1'b1;
    repeat (8) @(negedge clkDspIn);

    // bus still works after reset
    b = cyc; push(b+4, 0, 1, 8'h01); push(b+5, 0, 0, 8'h01);
    strobe(1, 0, 11'h400, 2, 8);

`ifdef DSP_BUS_CTL_WDOG_EN
    // idle timeout 100 cycles after the last hit
    b = cyc;
    push(b+4, 0, 1, 8'h03); push(b+5, 0, 0, 8'h03);
    push(b+104, 1, 0, 8'h00); push(b+105, 0, 0, 8'h00);
    strobe(1, 0, 11'h401, 2, 0);
    repeat (110) @(negedge clkDspIn);
    // hit on the terminal cycle suppresses the trip and restarts the count
    b = cyc;
    push(b+4, 0, 1, 8'h02); push(b+5, 0, 0, 8'h02);
    push(b+104, 0, 1, 8'h00); push(b+105, 0, 0, 8'h00);
    push(b+204, 1, 0, 8'h00); push(b+205, 0, 0, 8'h00);
    strobe(1, 0, 11'h401, 2, 0);
    repeat (98) @(negedge clkDspIn);
    strobe(0, 1, 11'h401, 2, 110);
`endif

    repeat (20) @(negedge clkDspIn);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got=%0d required=0 (next cyc=%0d)", sb.size(), sb[0].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
